shift_queue_mc: RTL
===================

// Module: shift_queue_mc
// PURPOSE
//  Multi-channel, parametrised shift-register queue for buffering feature-map/weight words between
//  conv/pool stages. CHANNELS lanes share one push/pop control; selectable FIFO or LIFO order.
//  Adds full/empty/count status, registered 1-cycle read with dout_vld, and defined push+pop
//  behaviour at every occupancy.
// PARAMETERS
//  WIDTH     8   bits per channel word
//  DEPTH     3   entries per channel (>=2)
//  CHANNELS  1   parallel lanes, packed LSB-first: lane k = bits [WIDTH*(k+1)-1 : WIDTH*k]
//  MODE      0   0 = FIFO (oldest out), 1 = LIFO (newest out)
//  CW        $clog2(DEPTH+1)  count width (derived, localparam)
// PORTS
//  clk      in   1               clock, all logic on posedge
//  rst      in   1               synchronous reset, active-high
//  ce       in   1               clock enable; 0 freezes all state
//  push     in   1               write request (din captured when accepted)
//  pop      in   1               read request
//  din      in   WIDTH*CHANNELS  write data, all lanes
//  dout     out  WIDTH*CHANNELS  read data, registered, held between pops
//  dout_vld out  1               1-cycle pulse: dout updated by accepted pop
//  full     out  1               count == DEPTH
//  empty    out  1               count == 0
//  count    out  CW              occupied entries
// BEHAVIOUR
//  - Reset (rst=1 at posedge, overrides ce): storage=0, count=0, dout=0, dout_vld=0, empty=1, full=0.
//  - Storage: per-lane shift register, index 0 = newest; accepted push shifts all entries up one
//    and writes din to index 0. full/empty combinational from count.
//  - ce=0: storage, count, dout unchanged; dout_vld=0.
//  - Accept rules (ce=1): push_ok = push & (!full | pop_ok); pop_ok = pop & !empty.
//    Push alone when full: dropped, no state change. Pop when empty: ignored, dout_vld=0.
//  - Read latency 1: pop_ok at edge N -> dout and dout_vld=1 valid after edge N; dout holds after.
//  - FIFO pop: dout <= entry[count-1]. LIFO pop: dout <= entry[0], entries shift down by one.
//  - count: +1 push_ok only, -1 pop_ok only, unchanged for both or neither.
//  - Simultaneous push+pop, non-empty: FIFO outputs oldest and shifts din in (legal when full);
//    LIFO outputs entry[0] then replaces entry[0] with din (no shift). Count unchanged.
//  - Simultaneous push+pop, empty: pop ignored (no bypass), push accepted, count=1, dout_vld=0.
//  - All lanes share control; lanes never diverge in occupancy.
//  - Vacated slots need not be cleared; only entries below count are observable.
// CONFIGURATION
//  SHIFT_QUEUE_ERR_EN defined: adds ports err_clr (in,1), ovf_err (out,1), udf_err (out,1).
//    ovf_err sets sticky on push while full without pop; udf_err sets sticky on pop while empty;
//    both cleared by rst or err_clr (err_clr wins over a same-cycle set). Ignored when ce=0.
//  Not defined: ports absent; dropped push/ignored pop are silent.
// TESTING
//  1 FIFO D3 C1: push 0x11,0x22,0x33 -> full=1,count=3; push 0x44 alone -> dropped, count=3;
//    pop x3 -> dout 0x11,0x22,0x33 each 1 cycle after pop with dout_vld pulse; empty=1.
//  2 LIFO D3: push 0xA1,0xA2,0xA3; pop x3 -> dout 0xA3,0xA2,0xA1; 4th pop -> dout holds 0xA1, dout_vld=0.
//  3 FIFO full, push 0x55 + pop same cycle -> dout=oldest, count stays 3; drain yields remaining
//    two then 0x55. LIFO count=2 push 0x66+pop -> dout=top, next pop -> 0x66.
//  4 Empty, push 0x77 + pop -> dout_vld=0, count=1; next pop -> dout=0x77.
//  5 CHANNELS=4 WIDTH=8: push 0x04030201,0x08070605; pop -> 0x04030201; per-lane ordering intact.
//  6 ce=0 with push/pop for 5 cycles -> no change; rst=1 mid-drain -> count=0,dout=0 next edge;
//    with SHIFT_QUEUE_ERR_EN: pop when empty -> udf_err=1 until err_clr pulse.

Source files
------------

// File: rtl/shift_queue_mc.sv
// Multi-lane shift-register queue (FIFO or LIFO) with shared push/pop control and a registered read port.
// Optional sticky overflow/underflow flags are built in when SHIFT_QUEUE_ERR_EN is defined.
module shift_queue_mc #(
    parameter  int WIDTH    = 8,
    parameter  int DEPTH    = 3,
    parameter  int CHANNELS = 1,
    parameter  int MODE     = 0,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH*CHANNELS-1:0] din,
`ifdef SHIFT_QUEUE_ERR_EN
    input  logic                      err_clr,
    output logic                      ovf_err,
    output logic                      udf_err,
`endif
    output logic [WIDTH*CHANNELS-1:0] dout,
    output logic                      dout_vld,
    output logic                      full,
    output logic                      empty,
    output logic [CW-1:0]             count
);

    localparam int DW = WIDTH * CHANNELS;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // All lanes share occupancy, so one entry holds every lane's word side by side.
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          dout_vld_q, dout_vld_d;
    logic          push_ok, pop_ok;
    logic [AW-1:0] rd_idx;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = ce & pop & ~empty;
    assign push_ok = ce & push & (~full | pop_ok);
    assign rd_idx  = AW'(count_q - CW'(1));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        mem_d      = mem_q;
        count_d    = count_q;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;

        if (pop_ok) begin
            dout_d     = (MODE == 0) ? mem_q[rd_idx] : mem_q[0];
            dout_vld_d = 1'b1;
        end

        if (MODE == 0) begin
            // FIFO pop only shrinks the observable window; the oldest word sits at count-1.
            if (push_ok) begin
                for (int i = DEPTH - 1; i > 0; i--) mem_d[i] = mem_q[i-1];
                mem_d[0] = din;
            end
        end else begin
            if (push_ok && pop_ok) begin
                mem_d[0] = din;
            end else if (push_ok) begin
                for (int i = DEPTH - 1; i > 0; i--) mem_d[i] = mem_q[i-1];
                mem_d[0] = din;
            end else if (pop_ok) begin
                for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
            end
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: storage is reset explicitly because the queue must come out of reset zero-filled.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            count_q    <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update together.
            mem_q      <= mem_d;
            count_q    <= count_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign count    = count_q;

`ifdef SHIFT_QUEUE_ERR_EN
    logic ovf_err_q, ovf_err_d;
    logic udf_err_q, udf_err_d;

    always_comb begin
        ovf_err_d = ovf_err_q;
        udf_err_d = udf_err_q;
        if (ce) begin
            if (err_clr) begin
                ovf_err_d = 1'b0;
                udf_err_d = 1'b0;
            end else begin
                if (push && full && !pop) ovf_err_d = 1'b1;
                if (pop && empty)         udf_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_err_q <= 1'b0;
            udf_err_q <= 1'b0;
        end else begin
            ovf_err_q <= ovf_err_d;
            udf_err_q <= udf_err_d;
        end
    end

    assign ovf_err = ovf_err_q;
    assign udf_err = udf_err_q;
`endif

endmodule
